// File: rtl/decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_p
// Description : MIPS decode stage: register file, decode, NPC/branch
//               resolution, Tuse/Tnew hazard stall and the D/E register.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module decode_stage_p #(
    parameter int          NREG       = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic [31:0] fwd_rs,
    input  logic [31:0] fwd_rt,
    input  logic [4:0]  e_a3,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        wb_en,
    input  logic [4:0]  wb_a3,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic [31:0] npc,
    output logic        flush_fd,
    output logic        de_valid,
    output logic [31:0] de_pc,
    output logic [31:0] de_instr,
    output logic [31:0] de_rd1,
    output logic [31:0] de_rd2,
    output logic [31:0] de_imm32,
    output logic [4:0]  de_a3,
    output logic [31:0] de_wd
);

    localparam int          AW     = $clog2(NREG);
    localparam logic [5:0]  c_NREG = 6'(NREG);

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_ORI     = 6'h0d;
    localparam logic [5:0] c_OP_LUI     = 6'h0f;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2b;
    localparam logic [5:0] c_FN_JR      = 6'h08;
    localparam logic [5:0] c_FN_ADDU    = 6'h21;
    localparam logic [5:0] c_FN_SUBU    = 6'h23;

    // Instruction fields
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm16;
    logic [25:0] w_imm26;

    assign w_op    = instr_d[31:26];
    assign w_rs    = instr_d[25:21];
    assign w_rt    = instr_d[20:16];
    assign w_rd    = instr_d[15:11];
    assign w_shamt = instr_d[10:6];
    assign w_funct = instr_d[5:0];
    assign w_imm16 = instr_d[15:0];
    assign w_imm26 = instr_d[25:0];

    // Decode
    logic        w_use_rs, w_use_rt;
    logic [1:0]  w_tuse_rs, w_tuse_rt;
    logic [4:0]  w_a3_raw, w_a3;
    logic [31:0] w_imm32;
    logic        w_is_beq, w_is_bne, w_is_j, w_is_jal, w_is_jr;

    always_comb begin
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        w_tuse_rs = 2'd0;
        w_tuse_rt = 2'd0;
        w_a3_raw  = 5'd0;
        w_imm32   = 32'd0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_j    = 1'b0;
        w_is_jal  = 1'b0;
        w_is_jr   = 1'b0;
        if (valid_d) begin
            case (w_op)
                c_OP_SPECIAL: begin
                    if (w_shamt == 5'd0) begin
                        if (w_funct == c_FN_ADDU || w_funct == c_FN_SUBU) begin
                            w_use_rs  = 1'b1;
                            w_use_rt  = 1'b1;
                            w_tuse_rs = 2'd1;
                            w_tuse_rt = 2'd1;
                            w_a3_raw  = w_rd;
                        end else if (w_funct == c_FN_JR) begin
                            w_use_rs  = 1'b1;
                            w_tuse_rs = 2'd0;
                            w_is_jr   = 1'b1;
                        end
                    end
                end
                c_OP_ORI: begin
                    w_use_rs  = 1'b1;
                    w_tuse_rs = 2'd1;
                    w_a3_raw  = w_rt;
                    w_imm32   = {16'd0, w_imm16};
                end
                c_OP_LUI: begin
                    w_a3_raw = w_rt;
                    w_imm32  = {w_imm16, 16'd0};
                end
                c_OP_LW: begin
                    w_use_rs  = 1'b1;
                    w_tuse_rs = 2'd1;
                    w_a3_raw  = w_rt;
                    w_imm32   = {{16{w_imm16[15]}}, w_imm16};
                end
                c_OP_SW: begin
                    w_use_rs  = 1'b1;
                    w_use_rt  = 1'b1;
                    w_tuse_rs = 2'd1;
                    w_tuse_rt = 2'd2;
                    w_imm32   = {{16{w_imm16[15]}}, w_imm16};
                end
                c_OP_BEQ, c_OP_BNE: begin
                    w_use_rs = 1'b1;
                    w_use_rt = 1'b1;
                    w_is_beq = (w_op == c_OP_BEQ);
                    w_is_bne = (w_op == c_OP_BNE);
                end
                c_OP_J: begin
                    w_is_j = 1'b1;
                end
                c_OP_JAL: begin
                    w_is_jal = 1'b1;
                    w_a3_raw = 5'd31;
                end
                default: ;
            endcase
        end
    end

    // Destinations outside the implemented register file collapse to $0
    assign w_a3 = ({1'b0, w_a3_raw} < c_NREG) ? w_a3_raw : 5'd0;

    // Register file with same-cycle write-through
    logic [31:0] r_grf [NREG];
    logic        w_we, w_rs_ok, w_rt_ok;
    logic [31:0] w_rd1, w_rd2;

    assign w_we    = wb_en && (wb_a3 != 5'd0) && ({1'b0, wb_a3} < c_NREG);
    assign w_rs_ok = (w_rs != 5'd0) && ({1'b0, w_rs} < c_NREG);
    assign w_rt_ok = (w_rt != 5'd0) && ({1'b0, w_rt} < c_NREG);

    assign w_rd1 = !w_rs_ok                    ? 32'd0 :
                   (wb_en && (wb_a3 == w_rs))  ? wb_data :
                   r_grf[w_rs[AW-1:0]];
    assign w_rd2 = !w_rt_ok                    ? 32'd0 :
                   (wb_en && (wb_a3 == w_rt))  ? wb_data :
                   r_grf[w_rt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_grf[i] <= 32'd0;
            end
        end else if (w_we) begin
            r_grf[wb_a3[AW-1:0]] <= wb_data;
        end
    end

    // Stall when a producer's result arrives later than the consumer needs it
    logic w_haz_rs, w_haz_rt, w_stall;

    assign w_haz_rs = w_use_rs && (w_rs != 5'd0) &&
                      (((e_a3 == w_rs) && (e_tnew > w_tuse_rs)) ||
                       ((m_a3 == w_rs) && (m_tnew > w_tuse_rs)));
    assign w_haz_rt = w_use_rt && (w_rt != 5'd0) &&
                      (((e_a3 == w_rt) && (e_tnew > w_tuse_rt)) ||
                       ((m_a3 == w_rt) && (m_tnew > w_tuse_rt)));
    assign w_stall  = valid_d && (w_haz_rs || w_haz_rt);
    assign stall    = w_stall;

    // Next-PC selection
    logic [31:0] w_pc_d4, w_br_tgt, w_j_tgt, w_tgt, w_link;
    logic        w_eq, w_taken;

    assign w_pc_d4  = pc_d + 32'd4;
    assign w_br_tgt = w_pc_d4 + {{14{w_imm16[15]}}, w_imm16, 2'b00};
    assign w_j_tgt  = {w_pc_d4[31:28], w_imm26, 2'b00};
    assign w_eq     = (fwd_rs == fwd_rt);
    assign w_taken  = (w_is_beq && w_eq) || (w_is_bne && !w_eq) ||
                      w_is_j || w_is_jal || w_is_jr;
    assign w_tgt    = w_is_jr                 ? fwd_rs  :
                      (w_is_j || w_is_jal)    ? w_j_tgt : w_br_tgt;

    assign npc = reset   ? RESET_PC :
                 w_stall ? pc_f     :
                 w_taken ? w_tgt    : (pc_f + 32'd4);

    generate
        if (DELAY_SLOT) begin : g_delay_slot
            assign w_link   = pc_d + 32'd8;
            assign flush_fd = 1'b0;
        end else begin : g_no_delay_slot
            // The slot instruction is already in F/D and must be squashed
            assign w_link   = pc_d + 32'd4;
            assign flush_fd = w_taken && !w_stall;
        end
    endgenerate

    // D/E pipeline register; a stall inserts a bubble
    logic        r_de_valid;
    logic [31:0] r_de_pc, r_de_instr, r_de_rd1, r_de_rd2, r_de_imm32, r_de_wd;
    logic [4:0]  r_de_a3;

    always_ff @(posedge clk) begin
        if (reset || w_stall) begin
            r_de_valid <= 1'b0;
            r_de_pc    <= 32'd0;
            r_de_instr <= 32'd0;
            r_de_rd1   <= 32'd0;
            r_de_rd2   <= 32'd0;
            r_de_imm32 <= 32'd0;
            r_de_a3    <= 5'd0;
            r_de_wd    <= 32'd0;
        end else begin
            r_de_valid <= valid_d;
            r_de_pc    <= pc_d;
            r_de_instr <= instr_d;
            r_de_rd1   <= w_rd1;
            r_de_rd2   <= w_rd2;
            r_de_imm32 <= w_imm32;
            r_de_a3    <= w_a3;
            r_de_wd    <= w_is_jal ? w_link : 32'd0;
        end
    end

    assign de_valid = r_de_valid;
    assign de_pc    = r_de_pc;
    assign de_instr = r_de_instr;
    assign de_rd1   = r_de_rd1;
    assign de_rd2   = r_de_rd2;
    assign de_imm32 = r_de_imm32;
    assign de_a3    = r_de_a3;
    assign de_wd    = r_de_wd;

endmodule
`default_nettype wire

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised decode stage for the five-stage MIPS pipeline. It holds the register file, decodes the supported subset, computes NPC and branch decisions, and detects load-use and branch-use hazards with a Tuse/Tnew stall rule. It also owns the D/E pipeline register, with bubble insertion. It supersedes the fixed 32-register, delay-slot-only decode used so far, and adds a selectable delay-slot mode and a configurable register count.

## Interface
Parameters:
- NREG, 32, number of architectural registers; power of two, 8..32; AW = $clog2(NREG)
- RESET_PC, 32'h0000_3000, PC value that resets propagate into de_pc's bubble? no: value placed on de_pc at reset is 0; RESET_PC is only used by F, passed through for npc at reset
- DELAY_SLOT, 1, 1 = MIPS delay slot (link = PC+8, no F/D flush); 0 = no delay slot (link = PC+4, taken redirect flushes F/D)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- pc_f  in  32  PC of the instruction in F
- pc_d, instr_d  in  32, 32  PC and instruction in D
- valid_d  in  1  D holds a real instruction
- fwd_rs, fwd_rt  in  32, 32  forwarded rs/rt values (from the forwarding muxes)
- e_a3, m_a3  in  5, 5  destination registers in E and M
- e_tnew, m_tnew  in  2, 2  remaining cycles until the result is available in E and M
- wb_en  in  1  GRF write enable from W
- wb_a3  in  5  GRF write address
- wb_data  in  32  GRF write data
- stall  out  1  hold the PC and the F/D register
- npc  out  32  next fetch PC
- flush_fd  out  1  clear the F/D register (DELAY_SLOT=0 only)
- de_valid, de_pc, de_instr  out  1, 32, 32  D/E register fields
- de_rd1, de_rd2, de_imm32  out  32 each  D/E register fields
- de_a3  out  5  D/E register field
- de_wd  out  32  D/E register field

## Operation
- Decoded subset:
  - addu/subu (op 0, funct 21h/23h): use rs, rt at Tuse 1; a3 = rd
  - ori: rs Tuse 1; a3 = rt; zero-extended immediate
  - lui: a3 = rt; imm32 = imm16<<16
  - lw: rs Tuse 1; a3 = rt; sign-extended immediate
  - sw: rs Tuse 1, rt Tuse 2; sign-extended immediate
  - beq/bne: rs, rt Tuse 0
  - j: no register use
  - jal: a3 = 31
  - jr: rs Tuse 0
  - any other encoding, or valid_d = 0: no use, a3 = 0, no redirect
- GRF:
  - NREG×32 registers; register 0 reads 0 and ignores writes.
  - Addresses ≥ NREG read 0 and ignore writes. An a3 ≥ NREG is forced to 0.
  - Write-through: when wb_en is high and wb_a3 equals the read address (nonzero, < NREG), the read returns wb_data in the same cycle.
- Stall rule, per used source s with nonzero address:
  - stall if (e_a3==s and e_tnew>Tuse) or (m_a3==s and m_tnew>Tuse).
  - stall is the OR over rs and rt. It is combinational and forced to 0 when valid_d = 0.
- NPC:
  - beq/bne: taken on the fwd_rs/fwd_rt compare; target = pc_d+4+(sext(imm16)<<2)
  - j/jal: {pc_d[31:28]+carry of pc_d+4, imm26, 2'b00}, i.e. upper bits of pc_d+4
  - jr: fwd_rs
  - otherwise: pc_f+4
  - While stall=1, npc = pc_f (hold).
- flush_fd = taken redirect and not stall and DELAY_SLOT==0; constant 0 when DELAY_SLOT=1.
- Link value: de_wd = pc_d+8 (DELAY_SLOT=1) or pc_d+4 (DELAY_SLOT=0) for jal; otherwise 0.

## Timing
- D/E register updates on every rising edge:
  - reset: all de_* outputs become 0.
  - stall: loads a bubble (all de_* = 0).
  - otherwise: loads the decoded fields; de_valid = valid_d.
- GRF:
  - Reset clears all registers in one cycle.
  - A write lands at the edge; reads are combinational.
  - Simultaneous reset and wb_en: reset wins.
- stall, npc, and flush_fd are combinational from the same-cycle inputs; zero latency.
- Decode-to-E latency is one cycle.
- Reset asserted mid-stall clears the bubble state; the first cycle after reset has stall = 0 unless the inputs demand it.
- In the same cycle as a stall, flush_fd is 0 (the redirect is deferred until the operands are ready).

## Test plan
- Reset: reset=1 for 2 edges with valid_d=1, instr_d=addu $3,$1,$2 -> all de_* = 0 after release edge; GRF reads 0 for every register.
- Write-through: wb_en=1, wb_a3=5, wb_data=32'h1234, instr_d=addu $6,$5,$0 -> same-cycle internal rd1 = 32'h1234; next edge de_rd1=32'h1234, de_a3=6. Write to $0 -> $0 still reads 0.
- Load-use on branch: beq $8,$9 with e_a3=8, e_tnew=2 -> stall=1, npc=pc_f, next de_valid=0. Then m_a3=8, m_tnew=1 -> still stall. Then m_tnew=0 -> stall=0, branch resolves.
- sw rt Tuse 2: sw $4,0($1) with e_a3=4, e_tnew=2 -> stall=0; with e_tnew=3 -> stall=1.
- Taken beq: pc_d=32'h3004, imm16=16'hFFFF, fwd_rs=fwd_rt=7 -> npc=32'h3004. DELAY_SLOT=1: flush_fd=0. DELAY_SLOT=0: flush_fd=1.
- jal and NREG=8:
  - jal at pc_d=32'h3010 -> de_a3=31, de_wd=32'h3018 (DELAY_SLOT=1) or 32'h3014 (DELAY_SLOT=0).
  - With NREG=8, that de_a3 is forced to 0.
  - With NREG=8, wb to register 12 is ignored and reads of register 12 return 0.
